stepper_motor_axis_scheduler: RTL and testbench

Time-shares one `stepper_motor_control_calc` acceleration pipeline between `NUM_AXES` stepper axes. On each control-period `trigger` it walks the enabled axes in ascending index order. For each axis it drives that axis's target position, current position and current velocity into the calc pipeline, pulses `calc_start`, holds the operands until `calc_out_valid`, and latches the signed acceleration into the axis's output register. It sits between the per-axis motion state registers and the single shared calc instance.

---
 rtl/stepper_motor_sched_pkg.sv | 17 +
 rtl/stepper_motor_next_axis.sv | 29 ++
 rtl/stepper_motor_axis_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_stepper_motor_axis_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_motor_sched_pkg.sv
// rtl/stepper_motor_sched_pkg.sv - shared constants for the stepper axis scheduler
// Purpose: scheduler state encoding and the index-width helper.
// Ports: none (package).
package stepper_motor_sched_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    // A single axis still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stepper_motor_next_axis.sv
// rtl/stepper_motor_next_axis.sv - priority encoder picking the next enabled axis
// Purpose: return the lowest set bit of i_mask strictly above i_idx, or the
//          lowest set bit overall when i_from_start is high.
// Ports:   i_mask (axis snapshot), i_idx (current axis), i_from_start,
//          o_idx (next axis), o_found (a candidate exists).
module stepper_motor_next_axis #(
    parameter int NUM_AXES  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_AXES-1:0]  i_mask,
    input  logic [IDX_WIDTH-1:0] i_idx,
    input  logic                 i_from_start,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_found
);

    // Scan downwards so the lowest qualifying axis is the last to win.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NUM_AXES - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_from_start || (i > int'(i_idx)))) begin
                o_idx   = IDX_WIDTH'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stepper_motor_axis_scheduler.sv
// rtl/stepper_motor_axis_scheduler.sv - time-shares one acceleration calc across stepper axes
// Purpose: on each accepted trigger, walk the enabled axes in ascending order,
//          feed each axis's operands to the shared calc, and latch the result.
// Ports:   clk, reset (sync, active-high), i_cke (global clock enable),
//          i_enable / i_axis_en / i_trigger / i_clear_err (control),
//          i_s_target_x / i_s_cur_x / i_s_cur_v (packed per-axis motion state),
//          o_calc_* / o_calc_start, i_calc_out_a / i_calc_out_valid (calc link),
//          o_m_a / o_m_a_valid / o_m_done (results), o_busy / o_overrun /
//          o_timeout_err (status).
module stepper_motor_axis_scheduler
    import stepper_motor_sched_pkg::*;
#(
    parameter int NUM_AXES = 4,
    parameter int X_WIDTH  = 48,
    parameter int V_WIDTH  = 16,
    parameter int A_WIDTH  = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_cke,
    input  logic                              i_enable,
    input  logic [NUM_AXES-1:0]               i_axis_en,
    input  logic                              i_trigger,
    input  logic                              i_clear_err,
    input  logic [NUM_AXES*X_WIDTH-1:0]       i_s_target_x,
    input  logic [NUM_AXES*X_WIDTH-1:0]       i_s_cur_x,
    input  logic [NUM_AXES*(V_WIDTH+1)-1:0]   i_s_cur_v,
    output logic [X_WIDTH-1:0]                o_calc_target_x,
    output logic [X_WIDTH-1:0]                o_calc_cur_x,
    output logic [V_WIDTH:0]                  o_calc_cur_v,
    output logic                              o_calc_start,
    input  logic [A_WIDTH:0]                  i_calc_out_a,
    input  logic                              i_calc_out_valid,
    output logic [NUM_AXES*(A_WIDTH+1)-1:0]   o_m_a,
    output logic [NUM_AXES-1:0]               o_m_a_valid,
    output logic                              o_m_done,
    output logic                              o_busy,
    output logic                              o_overrun,
    output logic                              o_timeout_err
);

    localparam int IDX_WIDTH = idx_width(NUM_AXES);
    localparam int AW1       = A_WIDTH + 1;
    localparam int VW1       = V_WIDTH + 1;
    localparam int T_W       = $clog2(TIMEOUT + 1);

    logic [2:0]               r_state;
    logic [IDX_WIDTH-1:0]     r_idx;
    logic [NUM_AXES-1:0]      r_mask;
    logic [T_W-1:0]           r_timer;
    logic [X_WIDTH-1:0]       r_calc_target_x;
    logic [X_WIDTH-1:0]       r_calc_cur_x;
    logic [V_WIDTH:0]         r_calc_cur_v;
    logic                     r_calc_start;
    logic [NUM_AXES*AW1-1:0]  r_m_a;
    logic [NUM_AXES-1:0]      r_m_a_valid;
    logic                     r_m_done;
    logic                     r_busy;
    logic                     r_overrun;
    logic                     r_timeout_err;

    logic                     w_in_idle;
    logic [NUM_AXES-1:0]      w_mask;
    logic [IDX_WIDTH-1:0]     w_next_idx;
    logic                     w_found;
    logic [X_WIDTH-1:0]       w_sel_target_x;
    logic [X_WIDTH-1:0]       w_sel_cur_x;
    logic [V_WIDTH:0]         w_sel_cur_v;

    // In IDLE the live axis_en is searched so the first axis can be loaded
    // on the same edge that takes the snapshot.
    assign w_in_idle = (r_state == S_IDLE);
    assign w_mask    = w_in_idle ? i_axis_en : r_mask;

    stepper_motor_next_axis #(
        .NUM_AXES  (NUM_AXES),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_next_axis (
        .i_mask       (w_mask),
        .i_idx        (r_idx),
        .i_from_start (w_in_idle),
        .o_idx        (w_next_idx),
        .o_found      (w_found)
    );

    always_comb begin
        w_sel_target_x = '0;
        w_sel_cur_x    = '0;
        w_sel_cur_v    = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (IDX_WIDTH'(i) == w_next_idx) begin
                w_sel_target_x = i_s_target_x[i*X_WIDTH +: X_WIDTH];
                w_sel_cur_x    = i_s_cur_x[i*X_WIDTH +: X_WIDTH];
                w_sel_cur_v    = i_s_cur_v[i*VW1 +: VW1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_mask          <= '0;
            r_timer         <= '0;
            r_calc_target_x <= '0;
            r_calc_cur_x    <= '0;
            r_calc_cur_v    <= '0;
            r_calc_start    <= 1'b0;
            r_m_a           <= '0;
            r_m_a_valid     <= '0;
            r_m_done        <= 1'b0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else if (i_cke) begin
            r_calc_start <= 1'b0;
            r_m_a_valid  <= '0;
            r_m_done     <= 1'b0;

            if (i_clear_err) begin
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end else if (i_trigger && !w_in_idle) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_trigger && i_enable) begin
                        r_mask <= i_axis_en;
                        r_busy <= 1'b1;
                        if (w_found) begin
                            r_idx           <= w_next_idx;
                            r_calc_target_x <= w_sel_target_x;
                            r_calc_cur_x    <= w_sel_cur_x;
                            r_calc_cur_v    <= w_sel_cur_v;
                            r_calc_start    <= 1'b1;
                            r_state         <= S_ISSUE;
                        end else begin
                            r_m_done <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Operands stay put here: the calc reads cur_v a stage
                    // after the positions.
                    if (i_calc_out_valid) begin
                        for (int i = 0; i < NUM_AXES; i++) begin
                            if (IDX_WIDTH'(i) == r_idx) begin
                                r_m_a[i*AW1 +: AW1] <= i_calc_out_a;
                                r_m_a_valid[i]      <= 1'b1;
                            end
                        end
                        if (w_found) begin
                            r_idx           <= w_next_idx;
                            r_calc_target_x <= w_sel_target_x;
                            r_calc_cur_x    <= w_sel_cur_x;
                            r_calc_cur_v    <= w_sel_cur_v;
                            r_calc_start    <= 1'b1;
                            r_state         <= S_ISSUE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (r_timer == T_W'(TIMEOUT - 1)) begin
                        for (int i = 0; i < NUM_AXES; i++) begin
                            if (IDX_WIDTH'(i) == r_idx) begin
                                r_m_a[i*AW1 +: AW1] <= '0;
                            end
                        end
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ERROR;
                    end else begin
                        r_timer <= r_timer + T_W'(1);
                    end
                end
                S_DONE: begin
                    // An empty sweep arrives with m_done already raised; a
                    // real sweep spends one settling cycle before the pulse.
                    if (r_m_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_m_done <= 1'b1;
                    end
                end
                S_ERROR: begin
                    // Parked until software acknowledges, so a late result
                    // cannot land on the wrong axis.
                    if (i_clear_err) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_calc_target_x = r_calc_target_x;
    assign o_calc_cur_x    = r_calc_cur_x;
    assign o_calc_cur_v    = r_calc_cur_v;
    assign o_calc_start    = r_calc_start;
    assign o_m_a           = r_m_a;
    assign o_m_a_valid     = r_m_a_valid;
    assign o_m_done        = r_m_done;
    assign o_busy          = r_busy;
    assign o_overrun       = r_overrun;
    assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_stepper_motor_axis_scheduler.sv
// tb/tb_stepper_motor_axis_scheduler.sv - scoreboard bench for the stepper axis scheduler
module tb_stepper_motor_axis_scheduler;

    localparam int N   = 4;
    localparam int XW  = 48;
    localparam int VW  = 16;
    localparam int AW  = 16;
    localparam int TO  = 24;
    localparam int L   = 20;
    localparam int AW1 = AW + 1;

    localparam int K_STROBE = 0;
    localparam int K_DONE   = 1;
    localparam int K_TO     = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cke = 1'b1;
    logic enable = 1'b1;
    logic trigger = 1'b0;
    logic clear_err = 1'b0;
    logic [N-1:0] axis_en = '0;
    logic [N*XW-1:0] s_target_x;
    logic [N*XW-1:0] s_cur_x;
    logic [N*(VW+1)-1:0] s_cur_v;
    logic [XW-1:0] tb_target [N];
    logic [XW-1:0] tb_cur_x [N];
    logic [VW:0]   tb_cur_v [N];

    logic [XW-1:0] calc_target_x;
    logic [XW-1:0] calc_cur_x;
    logic [VW:0]   calc_cur_v;
    logic          calc_start;
    logic [AW:0]   calc_out_a;
    logic          calc_out_valid;
    logic [N*AW1-1:0] m_a;
    logic [N-1:0]  m_a_valid;
    logic          m_done;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    // calc pipeline stand-in
    logic          cm_valid;
    logic          cm_samp;
    logic [AW:0]   cm_out;
    logic [XW-1:0] cm_pend;
    logic [XW-1:0] cm_sum;
    int            cm_cnt;
    logic          never_valid = 1'b0;
    logic          stray = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic te_prev = 1'b0;

    typedef struct {
        int          kind;
        int          axis;
        logic [AW:0] a;
        int          cyc;
    } ev_t;
    ev_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        s_target_x = '0;
        s_cur_x    = '0;
        s_cur_v    = '0;
        for (int i = 0; i < N; i++) begin
            s_target_x[i*XW +: XW]       = tb_target[i];
            s_cur_x[i*XW +: XW]          = tb_cur_x[i];
            s_cur_v[i*(VW+1) +: (VW+1)]  = tb_cur_v[i];
        end
    end

    assign cm_sum         = cm_pend + {{(XW-VW-1){calc_cur_v[VW]}}, calc_cur_v};
    assign calc_out_valid = cm_valid | stray;
    assign calc_out_a     = cm_out;

    // Latency L from start to valid; cur_v is read one cycle after start.
    always @(posedge clk) begin
        if (reset) begin
            cm_valid <= 1'b0;
            cm_samp  <= 1'b0;
            cm_cnt   <= 0;
            cm_out   <= '0;
            cm_pend  <= '0;
        end else if (cke) begin
            cm_samp <= calc_start;
            if (cm_samp) cm_out <= cm_sum[AW:0];
            if (calc_start) begin
                cm_pend  <= calc_target_x - calc_cur_x;
                cm_cnt   <= L - 1;
                cm_valid <= (L == 1) && !never_valid;
            end else if (cm_cnt > 0) begin
                cm_cnt   <= cm_cnt - 1;
                cm_valid <= (cm_cnt == 1) && !never_valid;
            end else begin
                cm_valid <= 1'b0;
            end
        end
    end

    stepper_motor_axis_scheduler #(
        .NUM_AXES (N),
        .X_WIDTH  (XW),
        .V_WIDTH  (VW),
        .A_WIDTH  (AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_cke            (cke),
        .i_enable         (enable),
        .i_axis_en        (axis_en),
        .i_trigger        (trigger),
        .i_clear_err      (clear_err),
        .i_s_target_x     (s_target_x),
        .i_s_cur_x        (s_cur_x),
        .i_s_cur_v        (s_cur_v),
        .o_calc_target_x  (calc_target_x),
        .o_calc_cur_x     (calc_cur_x),
        .o_calc_cur_v     (calc_cur_v),
        .o_calc_start     (calc_start),
        .i_calc_out_a     (calc_out_a),
        .i_calc_out_valid (calc_out_valid),
        .o_m_a            (m_a),
        .o_m_a_valid      (m_a_valid),
        .o_m_done         (m_done),
        .o_busy           (busy),
        .o_overrun        (overrun),
        .o_timeout_err    (timeout_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference acceleration for an axis: displacement plus velocity, truncated.
    function automatic logic [AW:0] ref_a(input int i);
        logic [XW-1:0] s;
        s = tb_target[i] - tb_cur_x[i] + {{(XW-VW-1){tb_cur_v[i][VW]}}, tb_cur_v[i]};
        return s[AW:0];
    endfunction

    task automatic push_ev(input int kind, input int axis, input logic [AW:0] a, input int c);
        ev_t e;
        e.kind = kind;
        e.axis = axis;
        e.a    = a;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // A sweep costs L+1 cycles per enabled axis, in ascending order.
    task automatic push_sweep(input logic [N-1:0] en, input int t0, input int shift);
        int j;
        j = 0;
        if (en == '0) begin
            push_ev(K_DONE, 0, '0, t0 + 1);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (en[i]) begin
                    push_ev(K_STROBE, i, ref_a(i), t0 + 2 + L + j * (L + 1) + shift);
                    j++;
                end
            end
            push_ev(K_DONE, 0, '0, t0 + 2 + j * (L + 1) + shift);
        end
    endtask

    task automatic pop_check(input int kind, input int axis, input logic [N*AW1-1:0] ma);
        ev_t e;
        logic [AW:0] a;
        checks++;
        if (sbq.size() == 0 || sbq[0].kind != kind) begin
            errors++;
            $display("FAIL unexpected_event: kind=%0d axis=%0d at cycle %0d, expected none of this kind", kind, axis, cyc);
            return;
        end
        e = sbq.pop_front();
        if (kind == K_TO) a = ma[e.axis*AW1 +: AW1];
        else              a = ma[axis*AW1 +: AW1];
        if (cyc != e.cyc || (kind == K_STROBE && (axis != e.axis || a != e.a)) ||
            (kind == K_TO && a != '0)) begin
            errors++;
            $display("FAIL event_k%0d: got axis=%0d a=%0h cycle=%0d, expected axis=%0d a=%0h cycle=%0d",
                     kind, axis, a, cyc, e.axis, (kind == K_TO) ? '0 : e.a, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (m_a_valid[i]) pop_check(K_STROBE, i, m_a);
            end
            if (m_done) pop_check(K_DONE, 0, m_a);
            if (timeout_err && !te_prev) pop_check(K_TO, 0, m_a);
        end
        te_prev <= reset ? 1'b0 : timeout_err;
    end

    task automatic randomize_axes();
        logic [63:0] r;
        for (int i = 0; i < N; i++) begin
            r = {$urandom(), $urandom()};
            tb_target[i] = r[XW-1:0];
            r = {$urandom(), $urandom()};
            tb_cur_x[i] = r[XW-1:0];
            r = {$urandom(), $urandom()};
            tb_cur_v[i] = r[VW:0];
        end
    endtask

    task automatic do_trigger(output int t0);
        @(posedge clk);
        #1 trigger = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int end_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < bound);
        end_cyc = cyc;
        chk("wait_idle_bound", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int te;
        int n;
        logic [VW:0] v_old;

        randomize_axes();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_m_a", m_a, '0);
        chk("reset_ops", {calc_target_x, calc_cur_x, calc_cur_v}, '0);
        chk("reset_pulses_flags", {calc_start, m_a_valid, m_done, overrun, timeout_err}, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fixed pattern 1011 with operand-hold probe on axis 0.
        axis_en = 4'b1011;
        do_trigger(t0);
        push_sweep(axis_en, t0, 0);
        v_old = tb_cur_v[0];
        tb_cur_v[0] = ~v_old;
        repeat (4) @(negedge clk);
        chk("cur_v_hold", calc_cur_v, v_old);
        wait_idle(200, te);
        chk("idle_cycle_after_sweep", te, t0 + 3 + 3 * (L + 1));
        chk("axis2_untouched", m_a[2*AW1 +: AW1], '0);

        // Trigger during a sweep only flags overrun.
        randomize_axes();
        axis_en = 4'b0110;
        do_trigger(t0);
        push_sweep(axis_en, t0, 0);
        while (cyc < t0 + 10) @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        chk("overrun_set", overrun, 1'b1);
        wait_idle(200, te);
        repeat (30) @(negedge clk);
        chk("no_second_sweep", busy, 1'b0);
        pulse_clear();
        @(negedge clk);
        chk("overrun_cleared", overrun, 1'b0);

        // Randomised sweeps, some with enable low.
        for (int it = 0; it < 12; it++) begin
            randomize_axes();
            axis_en = N'($urandom_range(0, 15));
            if (it % 5 == 4) begin
                enable  = 1'b0;
                axis_en = axis_en | 4'b0001;
                do_trigger(t0);
                @(negedge clk);
                chk("disabled_trigger_ignored", busy, 1'b0);
                enable = 1'b1;
            end else begin
                do_trigger(t0);
                push_sweep(axis_en, t0, 0);
                wait_idle(200, te);
            end
        end

        // Clock-enable stall mid-WAIT shifts everything by 5 cycles.
        randomize_axes();
        axis_en = 4'b0011;
        do_trigger(t0);
        push_sweep(axis_en, t0, 5);
        repeat (7) @(posedge clk);
        #1 cke = 1'b0;
        repeat (5) @(posedge clk);
        #1 cke = 1'b1;
        wait_idle(200, te);
        chk("cke_no_timeout", timeout_err, 1'b0);

        // Load axis 2 with a nonzero value, then let it time out.
        randomize_axes();
        if (ref_a(2) == '0) tb_target[2] = tb_target[2] + 1;
        axis_en = 4'b0100;
        do_trigger(t0);
        push_sweep(axis_en, t0, 0);
        wait_idle(200, te);
        never_valid = 1'b1;
        do_trigger(t0);
        push_ev(K_TO, 2, '0, t0 + 2 + TO);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_raised", timeout_err, 1'b1);
        chk("error_busy", busy, 1'b1);
        do_trigger(t0);
        @(negedge clk);
        chk("error_trigger_overrun", overrun, 1'b1);
        repeat (L + 10) @(negedge clk);
        chk("error_still_busy", busy, 1'b1);
        pulse_clear();
        @(negedge clk);
        chk("clear_flags", {overrun, timeout_err}, 2'b00);
        chk("clear_leaves_error", busy, 1'b0);
        never_valid = 1'b0;
        randomize_axes();
        axis_en = 4'b0101;
        do_trigger(t0);
        push_sweep(axis_en, t0, 0);
        wait_idle(200, te);

        // Reset mid-WAIT, then a stray valid must be ignored.
        randomize_axes();
        axis_en = 4'b1111;
        do_trigger(t0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_m_a", m_a, '0);
        chk("midreset_ops_flags", {calc_target_x, calc_cur_x, calc_cur_v, calc_start, m_a_valid, m_done, overrun, timeout_err}, '0);
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_valid_ignored", m_a_valid, '0);
        repeat (3) @(negedge clk);
        chk("stray_no_busy", busy, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
